// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode / register-file stage with registered D->E boundary.
//
// Decodes source and destination register IDs from the D-register instruction,
// reads a 15-entry register file written by write-back, resolves data hazards
// through a priority forwarding network and latches the result into the E
// register under hazard-unit stall/bubble control.
//
// Parameters:
//   DATA_W   - width of register values, valC, valP and forwarded values
//   RESET_SP - value loaded into %rsp (index 4) on reset
//   FWD_EN   - 1: forward from e, m, M and W; 0: W bypass only
//
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   D_*                        - instruction fields from the D register
//   E_stall, E_bubble          - E-register controls from the hazard unit
//   e_dstE/e_valE              - execute-stage ALU result
//   M_dstM/M_dstE/m_valM/M_valE- memory-stage results
//   W_dstM/W_dstE/W_valM/W_valE- write-back results (also register-file writes)
//   d_srcA, d_srcB             - combinational decoded sources for the hazard unit
//   E_*                        - registered E-stage outputs
module decode_stage #(
  parameter int unsigned        DATA_W   = 64,
  parameter logic [DATA_W-1:0]  RESET_SP = '0,
  parameter bit                 FWD_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [1:0]        D_stat,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstM,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        W_dstM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [DATA_W-1:0] W_valE,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [1:0]        E_stat,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [DATA_W-1:0] E_valC,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [DATA_W-1:0] rf [15];

  logic [3:0]        d_dstE;
  logic [3:0]        d_dstM;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;

  // Register ID decode
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (icode_e'(D_icode))
      I_RRMOVQ: begin d_srcA = D_rA;                 d_dstE = D_rB; end
      I_IRMOVQ: begin                                 d_dstE = D_rB; end
      I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB;                  end
      I_MRMOVQ: begin                d_srcB = D_rB; d_dstM = D_rA;   end
      I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB;   end
      I_CALL:   begin                d_srcB = RSP;  d_dstE = RSP;    end
      I_RET:    begin d_srcA = RSP;  d_srcB = RSP;  d_dstE = RSP;    end
      I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP;  d_dstE = RSP;    end
      I_POPQ:   begin d_srcA = RSP;  d_srcB = RSP;  d_dstE = RSP;
                      d_dstM = D_rA;                                 end
      default:  ;
    endcase
  end

  // Register-file read; RNONE matches no entry and therefore reads 0.
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (d_srcA == 4'(i)) rf_a = rf[i];
      if (d_srcB == 4'(i)) rf_b = rf[i];
    end
  end

  // Forwarding network, youngest producer first. RNONE sources are excluded
  // explicitly so an idle stage with dst=F can never be selected.
  always_comb begin
    d_valA = rf_a;
    if (D_icode == I_JXX || D_icode == I_CALL)
      d_valA = D_valP;
    else if (d_srcA != RNONE) begin
      if (FWD_EN && d_srcA == e_dstE)      d_valA = e_valE;
      else if (FWD_EN && d_srcA == M_dstM) d_valA = m_valM;
      else if (FWD_EN && d_srcA == M_dstE) d_valA = M_valE;
      else if (d_srcA == W_dstM)           d_valA = W_valM;
      else if (d_srcA == W_dstE)           d_valA = W_valE;
    end
  end

  always_comb begin
    d_valB = rf_b;
    if (d_srcB != RNONE) begin
      if (FWD_EN && d_srcB == e_dstE)      d_valB = e_valE;
      else if (FWD_EN && d_srcB == M_dstM) d_valB = m_valM;
      else if (FWD_EN && d_srcB == M_dstE) d_valB = M_valE;
      else if (d_srcB == W_dstM)           d_valB = W_valM;
      else if (d_srcB == W_dstE)           d_valB = W_valE;
    end
  end

  // Register file. Checking dstM before dstE per entry gives valM priority
  // on a same-register collision; index 15 has no entry, so writes vanish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++)
        rf[i] <= (i == 4) ? RESET_SP : '0;
    end else begin
      for (int unsigned i = 0; i < 15; i++) begin
        if (W_dstM == 4'(i))      rf[i] <= W_valM;
        else if (W_dstE == 4'(i)) rf[i] <= W_valE;
      end
    end
  end

  // D->E pipeline register: reset and bubble both insert a nop; bubble
  // overrides stall.
  always_ff @(posedge clk) begin
    if (!rst_n || E_bubble) begin
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_stat  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (!E_stall) begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_stat  <= D_stat;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_valC  <= D_valC;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// Two instances share all inputs: one with full forwarding, one W-bypass only.
// A behavioural model tracks the architectural register file and the expected
// E register; a compare process checks both instances every falling edge.
module tb_decode_stage;

  localparam logic [3:0] NO = 4'hF;
  localparam logic [3:0] SP = 4'h4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [1:0]  D_stat;
  logic        E_stall, E_bubble;
  logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;

  logic [3:0]  f_srcAd, f_srcBd, f_icode, f_ifun, f_dstE, f_dstM, f_srcA, f_srcB;
  logic [1:0]  f_stat;
  logic [63:0] f_valA, f_valB, f_valC;
  logic [3:0]  n_srcAd, n_srcBd, n_icode, n_ifun, n_dstE, n_dstM, n_srcA, n_srcB;
  logic [1:0]  n_stat;
  logic [63:0] n_valA, n_valB, n_valC;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(64), .RESET_SP(64'h100), .FWD_EN(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .M_dstE(M_dstE), .m_valM(m_valM), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_dstE(W_dstE), .W_valM(W_valM), .W_valE(W_valE),
    .d_srcA(f_srcAd), .d_srcB(f_srcBd),
    .E_icode(f_icode), .E_ifun(f_ifun), .E_stat(f_stat),
    .E_valA(f_valA), .E_valB(f_valB), .E_valC(f_valC),
    .E_dstE(f_dstE), .E_dstM(f_dstM), .E_srcA(f_srcA), .E_srcB(f_srcB)
  );

  decode_stage #(.DATA_W(64), .RESET_SP(64'h100), .FWD_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .M_dstE(M_dstE), .m_valM(m_valM), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_dstE(W_dstE), .W_valM(W_valM), .W_valE(W_valE),
    .d_srcA(n_srcAd), .d_srcB(n_srcBd),
    .E_icode(n_icode), .E_ifun(n_ifun), .E_stat(n_stat),
    .E_valA(n_valA), .E_valB(n_valB), .E_valC(n_valC),
    .E_dstE(n_dstE), .E_dstM(n_dstM), .E_srcA(n_srcA), .E_srcB(n_srcB)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_rf [16];
  bit          m_valid = 1'b0;
  logic [3:0]  x_icode, x_ifun, x_dstE, x_dstM, x_srcA, x_srcB;
  logic [1:0]  x_stat;
  logic [63:0] x_valA, x_valB, x_valC, xn_valA, xn_valB;

  // {srcA, srcB, dstE, dstM}
  function automatic logic [15:0] dec(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    case (ic)
      4'h2:    return {ra, NO, rb, NO};
      4'h3:    return {NO, NO, rb, NO};
      4'h4:    return {ra, rb, NO, NO};
      4'h5:    return {NO, rb, NO, ra};
      4'h6:    return {ra, rb, rb, NO};
      4'h8:    return {NO, SP, SP, NO};
      4'h9:    return {SP, SP, SP, NO};
      4'hA:    return {ra, SP, SP, NO};
      4'hB:    return {SP, SP, SP, ra};
      default: return {NO, NO, NO, NO};
    endcase
  endfunction

  // Value an operand register holds as seen from decode: the youngest
  // in-flight producer that targets it, else the architectural file.
  function automatic logic [63:0] operand(input logic [3:0] src, input bit fwd);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    if (src == NO) return 64'h0;
    ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    for (int k = fwd ? 0 : 3; k < 5; k++)
      if (ids[k] == src) return vals[k];
    return m_rf[src];
  endfunction

  always @(posedge clk) begin
    logic [15:0] d;
    bit          pc_op;
    d     = dec(D_icode, D_rA, D_rB);
    pc_op = (D_icode == 4'h7) || (D_icode == 4'h8);
    if (!rst_n || E_bubble) begin
      {x_icode, x_ifun, x_stat} = {4'h1, 4'h0, 2'h0};
      {x_valA, x_valB, x_valC, xn_valA, xn_valB} = '0;
      {x_srcA, x_srcB, x_dstE, x_dstM} = {NO, NO, NO, NO};
    end else if (!E_stall) begin
      {x_icode, x_ifun, x_stat} = {D_icode, D_ifun, D_stat};
      {x_srcA, x_srcB, x_dstE, x_dstM} = d;
      x_valA  = pc_op ? D_valP : operand(d[15:12], 1'b1);
      xn_valA = pc_op ? D_valP : operand(d[15:12], 1'b0);
      x_valB  = operand(d[11:8], 1'b1);
      xn_valB = operand(d[11:8], 1'b0);
      x_valC  = D_valC;
    end
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_rf[i] = (i == 4) ? 64'h100 : 64'h0;
      m_valid = 1'b1;
    end else begin
      // valM written last so it wins a collision
      if (W_dstE != NO) m_rf[W_dstE] = W_valE;
      if (W_dstM != NO) m_rf[W_dstM] = W_valM;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [15:0] d;
    if (m_valid) begin
      d = dec(D_icode, D_rA, D_rB);
      chk("f_d_srcA", {60'h0, f_srcAd}, {60'h0, d[15:12]});
      chk("f_d_srcB", {60'h0, f_srcBd}, {60'h0, d[11:8]});
      chk("n_d_srcA", {60'h0, n_srcAd}, {60'h0, d[15:12]});
      chk("n_d_srcB", {60'h0, n_srcBd}, {60'h0, d[11:8]});
      chk("f_E_icode", {60'h0, f_icode}, {60'h0, x_icode});
      chk("f_E_ifun",  {60'h0, f_ifun},  {60'h0, x_ifun});
      chk("f_E_stat",  {62'h0, f_stat},  {62'h0, x_stat});
      chk("f_E_valA",  f_valA, x_valA);
      chk("f_E_valB",  f_valB, x_valB);
      chk("f_E_valC",  f_valC, x_valC);
      chk("f_E_dstE",  {60'h0, f_dstE},  {60'h0, x_dstE});
      chk("f_E_dstM",  {60'h0, f_dstM},  {60'h0, x_dstM});
      chk("f_E_srcA",  {60'h0, f_srcA},  {60'h0, x_srcA});
      chk("f_E_srcB",  {60'h0, f_srcB},  {60'h0, x_srcB});
      chk("n_E_icode", {60'h0, n_icode}, {60'h0, x_icode});
      chk("n_E_valA",  n_valA, xn_valA);
      chk("n_E_valB",  n_valB, xn_valB);
      chk("n_E_valC",  n_valC, x_valC);
      chk("n_E_dstE",  {60'h0, n_dstE},  {60'h0, x_dstE});
      chk("n_E_dstM",  {60'h0, n_dstM},  {60'h0, x_dstM});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    D_icode = 4'h1; D_ifun = 4'h0; D_rA = NO; D_rB = NO;
    D_valC = '0; D_valP = '0; D_stat = 2'h0;
    E_stall = 1'b0; E_bubble = 1'b0;
    e_dstE = NO; M_dstM = NO; M_dstE = NO; W_dstM = NO; W_dstE = NO;
    e_valE = '0; m_valM = '0; M_valE = '0; W_valM = '0; W_valE = '0;
  endtask

  task automatic instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    D_icode = ic; D_rA = ra; D_rB = rb;
  endtask

  function automatic logic [3:0] rnd_dst();
    return ($urandom_range(0, 2) == 0) ? NO : 4'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();

    // reset and idle
    tick(); tick();
    chk("rst_icode", {60'h0, f_icode}, 64'h1);
    chk("rst_srcA",  {60'h0, f_srcA},  64'hF);
    chk("rst_dstM",  {60'h0, f_dstM},  64'hF);
    rst_n = 1'b1;
    instr(4'h6, 4'h4, NO);
    tick();
    chk("rsp_reset_valA", f_valA, 64'h100);
    chk("rnone_valB",     f_valB, 64'h0);

    // forward priority
    idle(); W_dstE = 4'h2; W_valE = 64'h44;
    tick();
    idle(); instr(4'h6, 4'h2, 4'h2);
    e_dstE = 4'h2; e_valE = 64'h11;
    M_dstE = 4'h2; M_valE = 64'h22;
    W_dstM = 4'h2; W_valM = 64'h33;
    tick();
    chk("fwd_e_valA", f_valA, 64'h11);
    chk("fwd_e_valB", f_valB, 64'h11);
    chk("nofwd_valA", n_valA, 64'h33);
    e_dstE = NO;
    tick();
    chk("fwd_M_valA", f_valA, 64'h22);
    M_dstE = NO;
    tick();
    chk("fwd_W_valA", f_valA, 64'h33);
    idle(); W_dstE = 4'h2; W_valE = 64'h44;
    tick();
    idle(); instr(4'h6, 4'h2, 4'h2);
    tick();
    chk("rf_valA",    f_valA, 64'h44);
    chk("nofwd_rf",   n_valA, 64'h44);

    // call / popq
    idle(); W_dstE = SP; W_valE = 64'h80;
    tick();
    idle(); instr(4'h8, NO, NO); D_valP = 64'h2000;
    tick();
    chk("call_valA", f_valA, 64'h2000);
    chk("call_valB", f_valB, 64'h80);
    chk("call_dstE", {60'h0, f_dstE}, 64'h4);
    chk("call_srcA", {60'h0, f_srcA}, 64'hF);
    idle(); instr(4'hB, 4'h3, NO);
    tick();
    chk("popq_srcA", {60'h0, f_srcA}, 64'h4);
    chk("popq_srcB", {60'h0, f_srcB}, 64'h4);
    chk("popq_dstE", {60'h0, f_dstE}, 64'h4);
    chk("popq_dstM", {60'h0, f_dstM}, 64'h3);

    // write collision and discarded RNONE write
    idle(); W_dstE = 4'h5; W_dstM = 4'h5; W_valE = 64'hAA; W_valM = 64'hBB;
    tick();
    idle(); instr(4'h2, 4'h5, 4'h0);
    tick();
    chk("collision_valA", f_valA, 64'hBB);
    idle(); W_valE = 64'hDEAD; W_valM = 64'hBEEF;
    tick();
    idle(); instr(4'h2, 4'h5, 4'h0);
    tick();
    chk("rnone_write", f_valA, 64'hBB);

    // stall hold with concurrent W write
    idle(); instr(4'h3, NO, 4'h3); D_valC = 64'h77;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); instr(4'h6, 4'h1, 4'h2); D_valC = 64'h1234; E_stall = 1'b1;
      if (i == 0) begin W_dstE = 4'h1; W_valE = 64'h55; end
      tick();
      chk("stall_icode", {60'h0, f_icode}, 64'h3);
      chk("stall_valC",  f_valC, 64'h77);
    end
    idle(); instr(4'h2, 4'h1, 4'h0);
    tick();
    chk("stall_wr_vis", f_valA, 64'h55);

    // stall + bubble together
    idle(); E_stall = 1'b1; E_bubble = 1'b1; instr(4'h6, 4'h1, 4'h2);
    tick();
    chk("bub_icode", {60'h0, f_icode}, 64'h1);
    chk("bub_dstE",  {60'h0, f_dstE},  64'hF);

    // reset during stall, W write dropped
    idle(); instr(4'h6, 4'h1, 4'h2);
    tick();
    E_stall = 1'b1; rst_n = 1'b0; W_dstE = 4'h6; W_valE = 64'h99;
    tick();
    chk("rst_stall_icode", {60'h0, f_icode}, 64'h1);
    chk("rst_stall_srcA",  {60'h0, f_srcA},  64'hF);
    rst_n = 1'b1;
    idle(); instr(4'h6, 4'h4, 4'h6);
    tick();
    chk("rst_drop_valB", f_valB, 64'h0);
    chk("rst_sp_valA",   f_valA, 64'h100);

    // randomized
    for (int c = 0; c < 400; c++) begin
      D_icode  = 4'($urandom_range(0, 12));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA     = ($urandom_range(0, 5) == 0) ? NO : 4'($urandom_range(0, 7));
      D_rB     = ($urandom_range(0, 5) == 0) ? NO : 4'($urandom_range(0, 7));
      D_valC   = {$urandom, $urandom};
      D_valP   = {$urandom, $urandom};
      D_stat   = 2'($urandom_range(0, 3));
      E_stall  = ($urandom_range(0, 5) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      rst_n    = ($urandom_range(0, 39) != 0);
      e_dstE = rnd_dst(); M_dstM = rnd_dst(); M_dstE = rnd_dst();
      W_dstM = rnd_dst(); W_dstE = rnd_dst();
      e_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
      M_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      W_valE = {$urandom, $urandom};
      tick();
    end

    idle(); rst_n = 1'b1;
    tick(); tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised Y86-64 decode/register-file stage with a registered D→E pipeline boundary. It decodes source and destination register IDs from `D_icode`, reads a 15-entry register file written by write-back, and resolves data hazards through a priority forwarding network. It sits between the fetch (D) register and the execute stage, with stall/bubble control from the hazard unit.

## Interface
Parameters:
- `DATA_W`, 64: width of register values, valC, valP and all forwarded values.
- `RESET_SP`, 0: value loaded into %rsp (index 4) on reset. All other registers reset to 0.
- `FWD_EN`, 1: 1 enables full forwarding (e, m, M, W). 0 keeps only the W-stage bypass; the hazard unit must stall on all other hazards.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. **One clock; reset is synchronous and active-low.**
- `D_icode`, `D_ifun` in 4: instruction fields from the D register.
- `D_rA`, `D_rB` in 4: register specifiers; 4'hF = RNONE.
- `D_valC`, `D_valP` in DATA_W: constant and next-PC.
- `D_stat` in 2: status, encoded 0 AOK, 1 HLT, 2 ADR, 3 INS.
- `E_stall`, `E_bubble` in 1: hazard-unit controls for the E register.
- `e_dstE` in 4, `e_valE` in DATA_W: execute-stage ALU result.
- `M_dstM`, `M_dstE` in 4; `m_valM`, `M_valE` in DATA_W: memory-stage results.
- `W_dstM`, `W_dstE` in 4; `W_valM`, `W_valE` in DATA_W: write-back results. These also drive the register-file write ports.
- `d_srcA`, `d_srcB` out 4: combinational decoded sources, fed to the hazard unit.
- `E_icode`, `E_ifun` out 4; `E_stat` out 2: registered.
- `E_valA`, `E_valB`, `E_valC` out DATA_W: registered.
- `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB` out 4: registered.

## Operation
- Register ID decode (RSP = 4, N = RNONE). Format is srcA / srcB / dstE / dstM:
  - 2 cmov: rA / N / rB / N
  - 3 irmovq: N / N / rB / N
  - 4 rmmovq: rA / rB / N / N
  - 5 mrmovq: N / rB / N / rA
  - 6 OPq: rA / rB / rB / N
  - 8 call: N / RSP / RSP / N
  - 9 ret: RSP / RSP / RSP / N
  - A pushq: rA / RSP / RSP / N
  - B popq: RSP / RSP / RSP / rA
  - Any other icode: all N.
- valA selection, first match wins:
  1. icode 7 or 8 → `D_valP`.
  2. srcA==`e_dstE` → `e_valE`.
  3. srcA==`M_dstM` → `m_valM`.
  4. srcA==`M_dstE` → `M_valE`.
  5. srcA==`W_dstM` → `W_valM`.
  6. srcA==`W_dstE` → `W_valE`.
  7. Otherwise, register file.
- valB uses the same chain without the valP term.
- RNONE never matches any forwarding source and always reads 0.
- When `FWD_EN`=0, the e and M terms are removed; the W terms remain.
- Register file: 15 × DATA_W, indices 0–14.
  - On each `clk` edge with `rst_n` high: write `W_valE` to `W_dstE`, then `W_valM` to `W_dstM`.
  - If both target the same register, valM wins.
  - Writes to index 15 are discarded.
- E register update priority:
  1. `!rst_n` → bubble, and the register file is reset.
  2. `E_bubble` → bubble.
  3. `E_stall` → hold.
  4. Otherwise, load the decoded values.
- `E_bubble` and `E_stall` asserted together: bubble wins.
- Bubble contents: icode 1 (nop), ifun 0, stat 0, valA/B/C 0, all src/dst 4'hF.

## Timing
- E outputs have a latency of one `clk` edge from D inputs.
- `d_srcA`/`d_srcB` and forwarding are combinational within the same cycle.
- Reset: every E output takes its bubble value after the first edge with `rst_n` low. Registers 0–14 become 0, except %rsp, which becomes `RESET_SP`.
- A register written by W at edge N is readable from the file in cycle N+1. In cycle N itself, the W bypass supplies the value, so read-during-write is never stale.
- Stall hold: E outputs stay bit-identical for as long as `E_stall` is high. The register file still accepts W writes during a stall.
- Reset asserted mid-stall overrides the stall. Any W write presented in the reset cycle is dropped.

## Test plan
- **Reset and idle.**
  - Stimulus: hold `rst_n`=0 for 2 cycles with `RESET_SP`=0x100; then issue OPq rA=4, rB=15 with no forwarding sources valid.
  - Required: after reset, E_icode=1 and all E_src/dst=F. After the load edge, E_valA=0x100 and E_valB=0.
- **Forward priority.**
  - Stimulus: OPq rA=2, rB=2. Drive `e_dstE`=2/0x11, `M_dstE`=2/0x22, `W_dstM`=2/0x33, with register 2 holding 0x44.
  - Required: E_valA=E_valB=0x11. Then remove e → 0x22; remove M → 0x33; remove W → 0x44.
- **`FWD_EN`=0.**
  - Stimulus: same stimulus as the forward-priority test.
  - Required: E_valA=0x33, and with W removed, 0x44.
- **Call / popq decode.**
  - call with `D_valP`=0x2000, register 4 = 0x80 → E_valA=0x2000, E_valB=0x80, E_dstE=4, E_srcA=F.
  - popq rA=3 → srcA=srcB=dstE=4, dstM=3.
- **Write collision.**
  - Stimulus: `W_dstE`=`W_dstM`=5 with valE=0xAA and valM=0xBB; next cycle decode rrmovq rA=5.
  - Required: E_valA=0xBB. A write with dst=F changes no register.
- **Stall / bubble.**
  - Load irmovq, then assert `E_stall` for 3 cycles with new D inputs → E outputs unchanged, and a concurrent W write to r1 is visible afterwards.
  - Assert `E_stall` and `E_bubble` together → nop bubble.
  - Drop `rst_n` during a stall → bubble.
